// File: rtl/clock_gate_scheduler.sv
// Clock-enable sequencer for N gated domains: round-robin wake arbitration,
// wake settling delay, and idle-timeout gating.
//
// Ports:
//   clk        free-running clock, all logic on posedge
//   reset      synchronous, active-high
//   activity   per-domain activity request
//   force_on   per-domain keep-on configuration (also counts as a request)
//   clk_en     enable to each domain's clock-gate cell
//   ready      domain clock stable and usable
//   wake_grant one-hot pulse on the edge a domain is granted wake
//   waking     high while any domain is in WAKE
module clock_gate_scheduler #(
  parameter int N_DOMAINS   = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DOMAINS-1:0] activity,
  input  logic [N_DOMAINS-1:0] force_on,
  output logic [N_DOMAINS-1:0] clk_en,
  output logic [N_DOMAINS-1:0] ready,
  output logic [N_DOMAINS-1:0] wake_grant,
  output logic                 waking
);

  localparam int PW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

  logic [1:0]           state_q [N_DOMAINS];
  logic [1:0]           state_d [N_DOMAINS];
  logic [IW-1:0]        idle_q  [N_DOMAINS];
  logic [IW-1:0]        idle_d  [N_DOMAINS];
  logic [WW-1:0]        wcnt_q;
  logic [WW-1:0]        wcnt_d;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [N_DOMAINS-1:0] req;
  logic [N_DOMAINS-1:0] cand;
  logic [N_DOMAINS-1:0] in_wake;
  logic [N_DOMAINS-1:0] grant;
  logic [N_DOMAINS-1:0] en_d;
  logic [N_DOMAINS-1:0] rdy_d;
  logic                 wk_d;
  logic                 any_wake;
  logic                 wake_done;

  always_comb begin
    req = activity | force_on;
    for (int i = 0; i < N_DOMAINS; i++) begin
      in_wake[i] = (state_q[i] == ST_WAKE);
      cand[i]    = (state_q[i] == ST_OFF) && req[i];
    end
    any_wake  = |in_wake;
    wake_done = (wcnt_q == '0);
  end

  // Only one wake in flight: the arbiter stays idle while any domain settles.
  always_comb begin : arb
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < N_DOMAINS; k++) begin
      idx = (int'(ptr_q) + k) % N_DOMAINS;
      if (!any_wake && !found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((idx + 1) % N_DOMAINS);
      end
    end
  end

  // One shared settle counter suffices since at most one domain wakes.
  always_comb begin
    wcnt_d = wcnt_q;
    if (|grant) begin
      wcnt_d = WAKE_LOAD;
    end else if (any_wake && !wake_done) begin
      wcnt_d = wcnt_q - WW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_DOMAINS; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = '0;
      case (state_q[i])
        ST_OFF: begin
          if (grant[i]) state_d[i] = ST_WAKE;
        end
        ST_WAKE: begin
          if (wake_done) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (req[i]) begin
            idle_d[i] = '0;
          end else if (idle_q[i] == IDLE_LAST) begin
            state_d[i] = ST_OFF;
          end else begin
            idle_d[i] = idle_q[i] + IW'(1);
          end
        end
        default: state_d[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    wk_d = 1'b0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      en_d[i]  = (state_d[i] != ST_OFF);
      rdy_d[i] = (state_d[i] == ST_ON);
      wk_d     = wk_d | (state_d[i] == ST_WAKE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        state_q[i] <= ST_OFF;
        idle_q[i]  <= '0;
      end
      wcnt_q     <= '0;
      ptr_q      <= '0;
      clk_en     <= '0;
      ready      <= '0;
      wake_grant <= '0;
      waking     <= 1'b0;
    end else begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
      end
      wcnt_q     <= wcnt_d;
      ptr_q      <= ptr_d;
      clk_en     <= en_d;
      ready      <= rdy_d;
      wake_grant <= grant;
      waking     <= wk_d;
    end
  end

endmodule

// File: tb/tb_clock_gate_scheduler.sv
// Bench for clock_gate_scheduler: directed vector table, corner sequences,
// and random traffic against a timestamp-based reference model.
module tb_clock_gate_scheduler;

  localparam int N  = 4;
  localparam int IC = 8;
  localparam int WC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] activity = '0;
  logic [N-1:0] force_on = '0;
  logic [N-1:0] clk_en;
  logic [N-1:0] ready;
  logic [N-1:0] wake_grant;
  logic         waking;

  int checks = 0;
  int errors = 0;

  clock_gate_scheduler #(
    .N_DOMAINS(N), .IDLE_CYCLES(IC), .WAKE_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset),
    .activity(activity), .force_on(force_on),
    .clk_en(clk_en), .ready(ready),
    .wake_grant(wake_grant), .waking(waking)
  );

  always #5 clk = ~clk;

  // Reference model: 0=off, 1=waking, 2=on; timing by edge timestamps.
  int           m_mode [N];
  int           m_wend [N];
  int           m_low  [N];
  int           m_ptr;
  int           m_edge;
  logic [N-1:0] m_gnt;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] a,
                            input logic [N-1:0] f);
    logic [N-1:0] rq;
    int pre [N];
    bit busy;
    rq     = a | f;
    m_gnt  = '0;
    m_edge = m_edge + 1;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0;
        m_low[i]  = 0;
      end
      m_ptr = 0;
      return;
    end
    busy = 0;
    for (int i = 0; i < N; i++) begin
      pre[i] = m_mode[i];
      if (pre[i] == 1) busy = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (pre[i] == 1 && m_edge == m_wend[i]) begin
        m_mode[i] = 2;
        m_low[i]  = 0;
      end else if (pre[i] == 2) begin
        m_low[i] = rq[i] ? 0 : m_low[i] + 1;
        if (m_low[i] >= IC) begin
          m_mode[i] = 0;
          m_low[i]  = 0;
        end
      end
    end
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (pre[j] == 0 && rq[j]) begin
          m_mode[j] = 1;
          m_wend[j] = m_edge + WC;
          m_gnt[j]  = 1'b1;
          m_ptr     = (j + 1) % N;
          break;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [N-1:0] en, rd;
    logic wk;
    wk = 0;
    for (int i = 0; i < N; i++) begin
      en[i] = (m_mode[i] != 0);
      rd[i] = (m_mode[i] == 2);
      if (m_mode[i] == 1) wk = 1;
    end
    return {en, rd, m_gnt, wk};
  endfunction

  task automatic step(input logic r, input logic [N-1:0] a,
                      input logic [N-1:0] f);
    reset    = r;
    activity = a;
    force_on = f;
    @(posedge clk);
    model_step(r, a, f);
    #1;
    check("model", {19'd0, clk_en, ready, wake_grant, waking},
          {19'd0, model_out()});
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] a;
    logic [N-1:0] en;
    logic [N-1:0] rdy;
    logic [N-1:0] gnt;
    logic         wk;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic [3:0] a,
                              input logic [3:0] en, input logic [3:0] rdy,
                              input logic [3:0] gnt, input logic wk);
    vec_t v;
    v.r = r; v.a = a; v.en = en; v.rdy = rdy; v.gnt = gnt; v.wk = wk;
    return v;
  endfunction

  initial begin
    logic [N-1:0] a, f;
    logic r;
    int dens;
    m_ptr  = 0;
    m_edge = 0;
    m_gnt  = '0;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_wend[i] = 0; m_low[i] = 0;
    end

    tbl[0]  = mk(1, 4'hF, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[1]  = mk(1, 4'hF, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[2]  = mk(1, 4'hF, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[3]  = mk(0, 4'hF, 4'b0001, 4'b0000, 4'b0001, 1);
    tbl[4]  = mk(0, 4'hF, 4'b0001, 4'b0000, 4'b0000, 1);
    tbl[5]  = mk(0, 4'hF, 4'b0001, 4'b0001, 4'b0000, 0);
    tbl[6]  = mk(0, 4'hF, 4'b0011, 4'b0001, 4'b0010, 1);
    tbl[7]  = mk(0, 4'hF, 4'b0011, 4'b0001, 4'b0000, 1);
    tbl[8]  = mk(0, 4'hF, 4'b0011, 4'b0011, 4'b0000, 0);
    tbl[9]  = mk(0, 4'hF, 4'b0111, 4'b0011, 4'b0100, 1);
    tbl[10] = mk(0, 4'hF, 4'b0111, 4'b0011, 4'b0000, 1);
    tbl[11] = mk(0, 4'hF, 4'b0111, 4'b0111, 4'b0000, 0);
    tbl[12] = mk(0, 4'hF, 4'b1111, 4'b0111, 4'b1000, 1);
    tbl[13] = mk(0, 4'hF, 4'b1111, 4'b0111, 4'b0000, 1);
    tbl[14] = mk(0, 4'hF, 4'b1111, 4'b1111, 4'b0000, 0);
    tbl[15] = mk(1, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[16] = mk(0, 4'h2, 4'b0010, 4'b0000, 4'b0010, 1);
    tbl[17] = mk(0, 4'h2, 4'b0010, 4'b0000, 4'b0000, 1);
    tbl[18] = mk(0, 4'h2, 4'b0010, 4'b0010, 4'b0000, 0);

    for (int v = 0; v < 19; v++) begin
      step(tbl[v].r, tbl[v].a, '0);
      check($sformatf("vec%0d", v),
            {19'd0, clk_en, ready, wake_grant, waking},
            {19'd0, tbl[v].en, tbl[v].rdy, tbl[v].gnt, tbl[v].wk});
    end

    // idle timeout with a rescue sample on the 8th edge
    step(1, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 4'b0100, '0);
    check("d2_on", {31'd0, ready[2]}, 32'd1);
    for (int i = 0; i < 7; i++) step(0, '0, '0);
    step(0, 4'b0100, '0);
    check("d2_rescued", {31'd0, ready[2]}, 32'd1);
    for (int i = 0; i < 7; i++) step(0, '0, '0);
    check("d2_low7", {30'd0, clk_en[2], ready[2]}, 32'd3);
    step(0, '0, '0);
    check("d2_off", {30'd0, clk_en[2], ready[2]}, 32'd0);

    // force_on keeps domain 3 alive indefinitely
    step(1, '0, '0);
    step(0, '0, 4'b1000);
    check("d3_grant", {28'd0, wake_grant}, 32'h8);
    for (int i = 0; i < 102; i++) step(0, '0, 4'b1000);
    check("d3_forced", {31'd0, ready[3]}, 32'd1);
    for (int i = 0; i < 7; i++) step(0, '0, '0);
    check("d3_low7", {31'd0, ready[3]}, 32'd1);
    step(0, '0, '0);
    check("d3_off", {30'd0, clk_en[3], ready[3]}, 32'd0);

    // reset during a wake
    step(1, '0, '0);
    step(0, 4'b0001, '0);
    check("d0_grant", {28'd0, wake_grant}, 32'h1);
    step(1, 4'b0001, '0);
    check("rst_wake", {19'd0, clk_en, ready, wake_grant, waking}, 32'd0);
    step(0, 4'b0001, '0);
    check("d0_regrant", {28'd0, wake_grant}, 32'h1);
    step(0, 4'b0001, '0);
    check("d0_notyet", {31'd0, ready[0]}, 32'd0);
    step(0, 4'b0001, '0);
    check("d0_ready", {31'd0, ready[0]}, 32'd1);

    // random traffic with varying density to exercise timeouts
    dens = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) dens = $urandom_range(0, 100);
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 99) < dens);
        f[i] = ($urandom_range(0, 199) == 0);
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, a, f);
      check("inv_rdy_en", {28'd0, ready & ~clk_en}, 32'd0);
      check("inv_onehot", {31'd0, $countones(wake_grant) > 1}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
